// File: rtl/uart_receiver_if.sv
// Receiver-side bus: the received word plus its status strobes.
// The receiver drives it through master; a consumer reads it through slave.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data;
  logic                 data_valid;
  logic                 frame_error;
  logic                 busy;

  modport master (
    output data,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    input data,
    input data_valid,
    input frame_error,
    input busy
  );
endinterface

// File: rtl/uart_receiver.sv
// Oversampling 8N1 UART receiver: synchronizer, 3-tap majority filter, mid-bit
// sampling FSM; publishes each good byte with a one-clock strobe.
module uart_receiver #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_BITS  = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            os_tick,
  input  logic            rxd,
  uart_receiver_if.master rx_bus
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS) + 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_t;

  logic [1:0]           sync_reg;
  logic [2:0]           hist_reg;
  state_t               state_reg, state_next;
  logic [CW-1:0]        os_cnt_reg, os_cnt_next;
  logic [BW-1:0]        bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 data_valid_reg, data_valid_next;
  logic                 frame_error_reg, frame_error_next;
  logic                 busy_reg, busy_next;
  logic                 rx_f;

  // Two of the last three tick samples decide the filtered line level.
  assign rx_f = (hist_reg[0] & hist_reg[1]) | (hist_reg[0] & hist_reg[2]) |
                (hist_reg[1] & hist_reg[2]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_reg        <= 2'b11;
      hist_reg        <= 3'b111;
      state_reg       <= IDLE;
      os_cnt_reg      <= '0;
      bit_idx_reg     <= '0;
      shift_reg       <= '0;
      data_reg        <= '0;
      data_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      busy_reg        <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[0], rxd};
      if (os_tick) begin
        hist_reg <= {hist_reg[1:0], sync_reg[1]};
      end
      state_reg       <= state_next;
      os_cnt_reg      <= os_cnt_next;
      bit_idx_reg     <= bit_idx_next;
      shift_reg       <= shift_next;
      data_reg        <= data_next;
      data_valid_reg  <= data_valid_next;
      frame_error_reg <= frame_error_next;
      busy_reg        <= busy_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    os_cnt_next  = os_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    if (os_tick) begin
      case (state_reg)
        IDLE: begin
          if (!rx_f) begin
            state_next  = START;
            os_cnt_next = '0;
          end
        end
        START: begin
          // Re-check the start bit half a bit in, so later samples land mid-bit.
          if (os_cnt_reg == HALF_LAST) begin
            os_cnt_next = '0;
            if (!rx_f) begin
              state_next   = DATA;
              bit_idx_next = '0;
            end else begin
              state_next = IDLE;
            end
          end else begin
            os_cnt_next = os_cnt_reg + CW'(1);
          end
        end
        DATA: begin
          if (os_cnt_reg == BIT_LAST) begin
            shift_next   = {rx_f, shift_reg[DATA_BITS-1:1]};
            os_cnt_next  = '0;
            bit_idx_next = bit_idx_reg + BW'(1);
            if (bit_idx_reg == IDX_LAST) begin
              state_next = STOP;
            end
          end else begin
            os_cnt_next = os_cnt_reg + CW'(1);
          end
        end
        STOP: begin
          if (os_cnt_reg == BIT_LAST) begin
            os_cnt_next = '0;
            state_next  = rx_f ? IDLE : WAIT_IDLE;
          end else begin
            os_cnt_next = os_cnt_reg + CW'(1);
          end
        end
        WAIT_IDLE: begin
          if (rx_f) begin
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  always_comb begin
    data_next        = data_reg;
    data_valid_next  = 1'b0;
    frame_error_next = 1'b0;
    if (os_tick && state_reg == STOP && os_cnt_reg == BIT_LAST) begin
      if (rx_f) begin
        data_next       = shift_reg;
        data_valid_next = 1'b1;
      end else begin
        frame_error_next = 1'b1;
      end
    end
    busy_next = (state_next != IDLE);
  end

  assign rx_bus.data        = data_reg;
  assign rx_bus.data_valid  = data_valid_reg;
  assign rx_bus.frame_error = frame_error_reg;
  assign rx_bus.busy        = busy_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: 8x oversampling, one tick every 4 clocks,
// so a nominal bit lasts 32 clocks.
module tb_uart_receiver;

  localparam int NOM = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic os_tick = 1'b0;
  logic rxd = 1'b1;

  int checks = 0;
  int passes = 0;

  int dv_cnt = 0;
  int fe_cnt = 0;
  int both_cnt = 0;
  int rise_cnt = 0;
  int fall_cnt = 0;
  logic busy_prev = 1'b0;
  logic [7:0] dv_q[$];

  uart_receiver_if #(.DATA_BITS(8)) bus ();

  uart_receiver #(.OVERSAMPLE(8), .DATA_BITS(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .os_tick (os_tick),
    .rxd     (rxd),
    .rx_bus  (bus)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      repeat (3) @(negedge clk);
      os_tick = 1'b1;
      @(negedge clk);
      os_tick = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (bus.data_valid) begin
      dv_cnt <= dv_cnt + 1;
      dv_q.push_back(bus.data);
    end
    if (bus.frame_error) fe_cnt <= fe_cnt + 1;
    if (bus.data_valid && bus.frame_error) both_cnt <= both_cnt + 1;
    if (bus.busy && !busy_prev) rise_cnt <= rise_cnt + 1;
    if (!bus.busy && busy_prev) fall_cnt <= fall_cnt + 1;
    busy_prev <= bus.busy;
  end

  task automatic idle_bits(input int n);
    rxd = 1'b1;
    repeat (n * NOM) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] val, input logic stop_bit,
                            input int bit_clks, output logic busy_mid);
    rxd = 1'b0;
    repeat (bit_clks) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = val[i];
      repeat (bit_clks / 2) @(negedge clk);
      if (i == 4) busy_mid = bus.busy;
      repeat (bit_clks - bit_clks / 2) @(negedge clk);
    end
    rxd = stop_bit;
    repeat (bit_clks) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    rxd = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.data !== 8'h00) $display("FAIL reset_data: got %h expected 00", bus.data); else passes++;
    checks++; if (bus.data_valid !== 1'b0) $display("FAIL reset_dv: got %b expected 0", bus.data_valid); else passes++;
    checks++; if (bus.frame_error !== 1'b0) $display("FAIL reset_fe: got %b expected 0", bus.frame_error); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passes++;
    $display("test_reset done");
  endtask

  task automatic test_idle;
    idle_bits(40);
    checks++; if (bus.busy !== 1'b0) $display("FAIL idle_busy: got %b expected 0", bus.busy); else passes++;
    checks++; if (dv_cnt !== 0) $display("FAIL idle_dv_cnt: got %0d expected 0", dv_cnt); else passes++;
    checks++; if (fe_cnt !== 0) $display("FAIL idle_fe_cnt: got %0d expected 0", fe_cnt); else passes++;
    checks++; if (rise_cnt !== 0) $display("FAIL idle_busy_rise: got %0d expected 0", rise_cnt); else passes++;
    $display("test_idle done");
  endtask

  task automatic test_back_to_back;
    logic b1, b2;
    int dv0, fall0;
    dv_q.delete();
    dv0 = dv_cnt;
    fall0 = fall_cnt;
    send_frame(8'h55, 1'b1, NOM, b1);
    send_frame(8'hA3, 1'b1, NOM, b2);
    idle_bits(2);
    checks++; if (dv_cnt - dv0 !== 2) $display("FAIL b2b_dv_cnt: got %0d expected 2", dv_cnt - dv0); else passes++;
    checks++; if (dv_q.size() < 1 || dv_q[0] !== 8'h55) $display("FAIL b2b_first: got %h expected 55", (dv_q.size() > 0) ? dv_q[0] : 8'hxx); else passes++;
    checks++; if (dv_q.size() < 2 || dv_q[1] !== 8'hA3) $display("FAIL b2b_second: got %h expected a3", (dv_q.size() > 1) ? dv_q[1] : 8'hxx); else passes++;
    checks++; if (b1 !== 1'b1 || b2 !== 1'b1) $display("FAIL b2b_busy_mid: got %b%b expected 11", b1, b2); else passes++;
    checks++; if (fall_cnt - fall0 !== 2) $display("FAIL b2b_busy_falls: got %0d expected 2", fall_cnt - fall0); else passes++;
    checks++; if (fe_cnt !== 0) $display("FAIL b2b_fe_cnt: got %0d expected 0", fe_cnt); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy_end: got %b expected 0", bus.busy); else passes++;
    $display("test_back_to_back: frames 55 a3 received %0d", dv_cnt - dv0);
  endtask

  task automatic test_glitch;
    logic bm;
    int dv0, rise0;
    dv0 = dv_cnt;
    rise0 = rise_cnt;
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    idle_bits(2);
    checks++; if (rise_cnt - rise0 !== 1) $display("FAIL glitch_start_entered: got %0d expected 1", rise_cnt - rise0); else passes++;
    checks++; if (dv_cnt - dv0 !== 0) $display("FAIL glitch_no_strobe: got %0d expected 0", dv_cnt - dv0); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL glitch_back_idle: got %b expected 0", bus.busy); else passes++;
    send_frame(8'h3C, 1'b1, NOM, bm);
    idle_bits(2);
    checks++; if (dv_cnt - dv0 !== 1) $display("FAIL glitch_next_dv: got %0d expected 1", dv_cnt - dv0); else passes++;
    checks++; if (bus.data !== 8'h3C) $display("FAIL glitch_next_data: got %h expected 3c", bus.data); else passes++;
    $display("test_glitch: next frame data %h", bus.data);
  endtask

  task automatic test_frame_error;
    logic bm;
    int dv0, fe0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    send_frame(8'h81, 1'b0, NOM, bm);
    rxd = 1'b0;
    repeat (3 * NOM) @(negedge clk);
    idle_bits(2);
    checks++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_strobes: got %0d expected 1", fe_cnt - fe0); else passes++;
    checks++; if (dv_cnt - dv0 !== 0) $display("FAIL ferr_no_dv: got %0d expected 0", dv_cnt - dv0); else passes++;
    checks++; if (bus.data !== 8'h3C) $display("FAIL ferr_data_held: got %h expected 3c", bus.data); else passes++;
    send_frame(8'h7E, 1'b1, NOM, bm);
    idle_bits(2);
    checks++; if (dv_cnt - dv0 !== 1) $display("FAIL ferr_next_dv: got %0d expected 1", dv_cnt - dv0); else passes++;
    checks++; if (bus.data !== 8'h7E) $display("FAIL ferr_next_data: got %h expected 7e", bus.data); else passes++;
    checks++; if (fe_cnt - fe0 !== 1) $display("FAIL ferr_total: got %0d expected 1", fe_cnt - fe0); else passes++;
    checks++; if (both_cnt !== 0) $display("FAIL ferr_both_high: got %0d expected 0", both_cnt); else passes++;
    $display("test_frame_error: data after recovery %h", bus.data);
  endtask

  task automatic test_reset_midframe;
    logic bm;
    logic [7:0] v;
    int dv0, fe0;
    v = 8'hF0;
    dv0 = dv_cnt;
    fe0 = fe_cnt;
    rxd = 1'b0;
    repeat (NOM) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rxd = v[i];
      repeat (NOM) @(negedge clk);
    end
    rxd = v[4];
    repeat (NOM / 2) @(negedge clk);
    checks++; if (bus.busy !== 1'b1) $display("FAIL rstmid_busy_before: got %b expected 1", bus.busy); else passes++;
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.data !== 8'h00) $display("FAIL rstmid_data: got %h expected 00", bus.data); else passes++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", bus.busy); else passes++;
    checks++; if (bus.data_valid !== 1'b0 || bus.frame_error !== 1'b0) $display("FAIL rstmid_strobes: got %b%b expected 00", bus.data_valid, bus.frame_error); else passes++;
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    idle_bits(3);
    checks++; if (dv_cnt - dv0 !== 0 || fe_cnt - fe0 !== 0) $display("FAIL rstmid_no_strobe: got dv %0d fe %0d expected 0 0", dv_cnt - dv0, fe_cnt - fe0); else passes++;
    send_frame(8'h0F, 1'b1, NOM, bm);
    idle_bits(2);
    checks++; if (bus.data !== 8'h0F) $display("FAIL rstmid_next_data: got %h expected 0f", bus.data); else passes++;
    checks++; if (dv_cnt - dv0 !== 1) $display("FAIL rstmid_next_dv: got %0d expected 1", dv_cnt - dv0); else passes++;
    $display("test_reset_midframe: next frame data %h", bus.data);
  endtask

  task automatic test_rate_offset;
    logic bm;
    int dv0, fe0;
    int rates[2];
    logic [7:0] vals[3];
    rates[0] = 33;
    rates[1] = 31;
    vals[0] = 8'h00;
    vals[1] = 8'hFF;
    vals[2] = 8'h96;
    fe0 = fe_cnt;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        dv0 = dv_cnt;
        send_frame(vals[k], 1'b1, rates[r], bm);
        idle_bits(2);
        checks++; if (dv_cnt - dv0 !== 1 || bus.data !== vals[k]) $display("FAIL rate_%0d_clk_%h: got dv %0d data %h expected dv 1 data %h", rates[r], vals[k], dv_cnt - dv0, bus.data, vals[k]); else passes++;
        $display("test_rate_offset: bit %0d clk sent %h got %h", rates[r], vals[k], bus.data);
      end
    end
    checks++; if (fe_cnt - fe0 !== 0) $display("FAIL rate_fe_cnt: got %0d expected 0", fe_cnt - fe0); else passes++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_back_to_back();
    test_glitch();
    test_frame_error();
    test_reset_midframe();
    test_rate_offset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
